// File: rtl/gpio_irq_ctrl.sv
// Fabric GPIO interrupt controller: per-channel synchroniser, debounce, edge/level
// detect and sticky pending bits, plus a masked-write output register.
module gpio_irq_ctrl #(
    parameter int NUM_GPIO        = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                    FAB_CCC_GL0,
    input  logic                    FAB_RESET_N,
    input  logic [NUM_GPIO-1:0]     GPIO_IN,
    input  logic [NUM_GPIO-1:0]     IRQ_EN,
    input  logic [2*NUM_GPIO-1:0]   IRQ_MODE,
    input  logic [NUM_GPIO-1:0]     IRQ_CLR,
    input  logic                    GPIO_OUT_WR,
    input  logic [NUM_GPIO-1:0]     GPIO_OUT_WMASK,
    input  logic [NUM_GPIO-1:0]     GPIO_OUT_WDATA,
    output logic [NUM_GPIO-1:0]     GPIO_OUT,
    output logic [NUM_GPIO-1:0]     GPIO_STATE,
    output logic [NUM_GPIO-1:0]     IRQ_PEND,
    output logic                    INT
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic [NUM_GPIO-1:0] sync_q [SYNC_STAGES];
    logic [NUM_GPIO-1:0] sync_s;
    logic [CW-1:0]       cnt_q [NUM_GPIO];
    logic [NUM_GPIO-1:0] stable_q;
    logic [NUM_GPIO-1:0] stable_d_q;
    logic [NUM_GPIO-1:0] pend_q;
    logic [NUM_GPIO-1:0] set_c;
    logic [NUM_GPIO-1:0] out_q;
    logic                int_q;

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            sync_q[0] <= GPIO_IN;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    // A new level is accepted only after it has differed from stable for DEBOUNCE_CYCLES cycles in a row.
    always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            stable_q   <= '0;
            stable_d_q <= '0;
            for (int i = 0; i < NUM_GPIO; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_d_q <= stable_q;
            for (int i = 0; i < NUM_GPIO; i++) begin
                if (sync_s[i] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_MAX) begin
                    stable_q[i] <= sync_s[i];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        set_c = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            case (IRQ_MODE[2*i +: 2])
                2'b00:   set_c[i] = stable_q[i] & ~stable_d_q[i];
                2'b01:   set_c[i] = ~stable_q[i] & stable_d_q[i];
                2'b10:   set_c[i] = stable_q[i] ^ stable_d_q[i];
                default: set_c[i] = stable_q[i];
            endcase
            set_c[i] = set_c[i] & IRQ_EN[i];
        end
    end

    // Set has priority over clear so an event coinciding with a clear is never lost.
    always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            pend_q <= '0;
            int_q  <= 1'b0;
        end else begin
            pend_q <= set_c | (pend_q & ~IRQ_CLR);
            int_q  <= |(pend_q & IRQ_EN);
        end
    end

    always_ff @(posedge FAB_CCC_GL0 or negedge FAB_RESET_N) begin
        if (!FAB_RESET_N) begin
            out_q <= '0;
        end else if (GPIO_OUT_WR) begin
            out_q <= (out_q & ~GPIO_OUT_WMASK) | (GPIO_OUT_WDATA & GPIO_OUT_WMASK);
        end
    end

    assign GPIO_OUT   = out_q;
    assign GPIO_STATE = stable_q;
    assign IRQ_PEND   = pend_q;
    assign INT        = int_q;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Scoreboard bench for gpio_irq_ctrl: the driver queues expected values with a due cycle,
// a monitor pops and compares them on the falling edge once they fall due.
module tb_gpio_irq_ctrl;

    localparam int N = 8;
    localparam int SIG_STATE = 0;
    localparam int SIG_PEND  = 1;
    localparam int SIG_INT   = 2;
    localparam int SIG_OUT   = 3;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   gin;
    logic [N-1:0]   en;
    logic [2*N-1:0] mode;
    logic [N-1:0]   clr;
    logic           wr;
    logic [N-1:0]   wmask;
    logic [N-1:0]   wdata;
    logic [N-1:0]   gpio_out;
    logic [N-1:0]   gpio_state;
    logic [N-1:0]   irq_pend;
    logic           int_o;

    typedef struct {
        int          due;
        int          sig;
        logic [N-1:0] mask;
        logic [N-1:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   cyc;
    int   tests_run;
    int   tests_failed;
    event chk_ev;

    gpio_irq_ctrl #(.NUM_GPIO(N), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut (
        .FAB_CCC_GL0    (clk),
        .FAB_RESET_N    (rst_n),
        .GPIO_IN        (gin),
        .IRQ_EN         (en),
        .IRQ_MODE       (mode),
        .IRQ_CLR        (clr),
        .GPIO_OUT_WR    (wr),
        .GPIO_OUT_WMASK (wmask),
        .GPIO_OUT_WDATA (wdata),
        .GPIO_OUT       (gpio_out),
        .GPIO_STATE     (gpio_state),
        .IRQ_PEND       (irq_pend),
        .INT            (int_o)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run did not end, expected end before 200000");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_at(input int dly, input int sig, input logic [N-1:0] mask,
                             input logic [N-1:0] val, input string name);
        exp_t e;
        e.due  = cyc + dly;
        e.sig  = sig;
        e.mask = mask;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic pulse_clr(input logic [N-1:0] m);
        clr = m;
        tick(1);
        clr = '0;
    endtask

    // scoreboard monitor
    function automatic logic [N-1:0] sample(input int sig);
        case (sig)
            SIG_STATE: return gpio_state;
            SIG_PEND:  return irq_pend;
            SIG_INT:   return {{(N-1){1'b0}}, int_o};
            default:   return gpio_out;
        endcase
    endfunction

    always begin
        @(negedge clk or chk_ev);
        for (int k = 0; k < exp_q.size(); ) begin
            if (exp_q[k].due <= cyc) begin
                logic [N-1:0] act;
                act = sample(exp_q[k].sig) & exp_q[k].mask;
                tests_run++;
                if (act !== (exp_q[k].val & exp_q[k].mask)) begin
                    tests_failed++;
                    $display("[TB] FAIL %s cycle %0d: got %h expected %h", exp_q[k].name, cyc,
                             act, exp_q[k].val & exp_q[k].mask);
                end
                exp_q.delete(k);
            end else begin
                k++;
            end
        end
    end

    // stimulus
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        gin   = '0;
        en    = '0;
        mode  = '0;
        clr   = '0;
        wr    = 1'b0;
        wmask = '0;
        wdata = '0;
        tick(2);
        expect_at(1, SIG_STATE, 8'hFF, 8'h00, "reset_state");
        expect_at(1, SIG_PEND,  8'hFF, 8'h00, "reset_pend");
        expect_at(1, SIG_INT,   8'h01, 8'h00, "reset_int");
        expect_at(1, SIG_OUT,   8'hFF, 8'h00, "reset_out");
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // ch0 rising edge latency and clear
        en = 8'h01;
        gin[0] = 1'b1;
        expect_at(5, SIG_STATE, 8'h01, 8'h00, "t1_state_early");
        expect_at(6, SIG_STATE, 8'h01, 8'h01, "t1_state");
        expect_at(6, SIG_PEND,  8'h01, 8'h00, "t1_pend_early");
        expect_at(7, SIG_PEND,  8'h01, 8'h01, "t1_pend");
        expect_at(7, SIG_INT,   8'h01, 8'h00, "t1_int_early");
        expect_at(8, SIG_INT,   8'h01, 8'h01, "t1_int");
        tick(9);
        tests_run++;
        if (irq_pend[0] !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL t1_pend_direct cycle %0d: got %b expected 1", cyc, irq_pend[0]);
        end
        expect_at(1, SIG_PEND, 8'h01, 8'h00, "t1_clr_pend");
        expect_at(2, SIG_INT,  8'h01, 8'h00, "t1_clr_int");
        pulse_clr(8'h01);
        tick(2);

        // ch1 glitch rejection, then an accepted 4-cycle pulse
        en = 8'h03;
        gin[1] = 1'b1;
        expect_at(6, SIG_STATE, 8'h02, 8'h00, "t2_glitch_state");
        expect_at(7, SIG_PEND,  8'h02, 8'h00, "t2_glitch_pend");
        expect_at(9, SIG_STATE, 8'h02, 8'h00, "t2_glitch_state_late");
        tick(3);
        gin[1] = 1'b0;
        tick(8);
        gin[1] = 1'b1;
        expect_at(5, SIG_STATE, 8'h02, 8'h00, "t2_pulse_state_early");
        expect_at(6, SIG_STATE, 8'h02, 8'h02, "t2_pulse_state");
        expect_at(7, SIG_PEND,  8'h02, 8'h02, "t2_pulse_pend");
        tick(4);
        gin[1] = 1'b0;
        tick(8);
        expect_at(1, SIG_PEND, 8'h02, 8'h00, "t2_clr");
        pulse_clr(8'h02);

        // ch2 level-high mode
        mode[5:4] = 2'b11;
        en = 8'h07;
        gin[2] = 1'b1;
        expect_at(7, SIG_PEND, 8'h04, 8'h04, "t3_level_pend");
        tick(8);
        expect_at(1, SIG_PEND, 8'h04, 8'h04, "t3_clr_ignored");
        expect_at(2, SIG_PEND, 8'h04, 8'h04, "t3_clr_ignored2");
        pulse_clr(8'h04);
        tick(1);
        gin[2] = 1'b0;
        expect_at(6, SIG_STATE, 8'h04, 8'h00, "t3_state_low");
        expect_at(8, SIG_PEND,  8'h04, 8'h04, "t3_sticky_low");
        tick(8);
        expect_at(1, SIG_PEND, 8'h04, 8'h00, "t3_clr_low");
        expect_at(5, SIG_PEND, 8'h04, 8'h00, "t3_stays_clear");
        pulse_clr(8'h04);
        tick(5);

        // ch3 disabled both-edge mode, then enable masking of INT
        mode[7:6] = 2'b10;
        gin[3] = 1'b1;
        expect_at(7, SIG_PEND, 8'h08, 8'h00, "t4_dis_rise");
        tick(8);
        gin[3] = 1'b0;
        expect_at(7, SIG_PEND,  8'h08, 8'h00, "t4_dis_fall");
        expect_at(7, SIG_STATE, 8'h08, 8'h00, "t4_state_low");
        tick(10);
        mode[7:6] = 2'b00;
        en = 8'h0F;
        gin[3] = 1'b1;
        expect_at(7, SIG_PEND, 8'h08, 8'h08, "t4_en_pend");
        expect_at(8, SIG_INT,  8'h01, 8'h01, "t4_en_int");
        tick(9);
        en = 8'h07;
        expect_at(1, SIG_INT,  8'h01, 8'h00, "t4_int_masked");
        expect_at(1, SIG_PEND, 8'h08, 8'h08, "t4_pend_kept");
        expect_at(3, SIG_PEND, 8'h08, 8'h08, "t4_pend_kept_late");
        tick(3);

        // ch4 set beats simultaneous clear
        en = 8'h1F;
        gin[4] = 1'b1;
        tick(6);
        clr = 8'h10;
        expect_at(1, SIG_PEND, 8'h10, 8'h10, "t5_set_wins");
        expect_at(2, SIG_PEND, 8'h10, 8'h10, "t5_set_wins_hold");
        tick(1);
        clr = '0;
        tick(2);

        // all channels rising together
        gin = '0;
        tick(12);
        expect_at(1, SIG_PEND, 8'hFF, 8'h00, "t5_all_cleared");
        pulse_clr(8'hFF);
        mode = '0;
        en = 8'hFF;
        tick(1);
        gin = 8'hFF;
        expect_at(6, SIG_STATE, 8'hFF, 8'hFF, "t5_all_state");
        expect_at(6, SIG_PEND,  8'hFF, 8'h00, "t5_all_pend_early");
        expect_at(7, SIG_PEND,  8'hFF, 8'hFF, "t5_all_pend");
        tick(9);

        // masked output register writes
        wr = 1'b1;
        wmask = 8'hFF;
        wdata = 8'hF0;
        expect_at(1, SIG_OUT, 8'hFF, 8'hF0, "t6_out_full");
        tick(1);
        wmask = 8'h0F;
        wdata = 8'hA5;
        expect_at(1, SIG_OUT, 8'hFF, 8'hF5, "t6_out_masked");
        tick(1);
        tests_run++;
        if (gpio_out !== 8'hF5) begin
            tests_failed++;
            $display("[TB] FAIL t6_out_direct cycle %0d: got %h expected f5", cyc, gpio_out);
        end
        wr = 1'b0;
        wmask = 8'hFF;
        wdata = 8'h00;
        expect_at(3, SIG_OUT, 8'hFF, 8'hF5, "t6_out_hold");
        tick(3);

        // asynchronous reset during a debounce, pins high through reset
        expect_at(1, SIG_PEND, 8'hFF, 8'h00, "t6_pre_clr");
        pulse_clr(8'hFF);
        gin = 8'h00;
        expect_at(2, SIG_STATE, 8'hFF, 8'hFF, "t6_state_before_rst");
        tick(3);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (gpio_state !== 8'h00 || irq_pend !== 8'h00 || gpio_out !== 8'h00 || int_o !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL rst_async_direct cycle %0d: state %h pend %h out %h int %b",
                     cyc, gpio_state, irq_pend, gpio_out, int_o);
        end
        expect_at(0, SIG_STATE, 8'hFF, 8'h00, "rst_async_state");
        expect_at(0, SIG_PEND,  8'hFF, 8'h00, "rst_async_pend");
        expect_at(0, SIG_INT,   8'h01, 8'h00, "rst_async_int");
        expect_at(0, SIG_OUT,   8'hFF, 8'h00, "rst_async_out");
        -> chk_ev;
        gin = 8'hFF;
        tick(3);
        rst_n = 1'b1;
        expect_at(5, SIG_STATE, 8'hFF, 8'h00, "rst_state_early");
        expect_at(6, SIG_PEND,  8'hFF, 8'h00, "rst_pend_early");
        expect_at(7, SIG_PEND,  8'hFF, 8'hFF, "rst_pend_rise");
        expect_at(8, SIG_INT,   8'h01, 8'h01, "rst_int_rise");
        tick(10);

        // final report
        for (int w = 0; w < 50 && exp_q.size() != 0; w++) tick(1);
        while (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s: never checked, due cycle %0d, now %0d", exp_q[0].name,
                     exp_q[0].due, cyc);
            exp_q.delete(0);
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
